// File: rtl/c432_attack_pkg.sv
// Shared definitions for the attack-side drivers of the key-locked c432 netlist:
// port widths, the pattern LFSR feedback taps and the query sequencer states.
package c432_attack_pkg;

    localparam int NUM_PI  = 36;
    localparam int NUM_KEY = 10;
    localparam int NUM_PO  = 7;

    // x^36 + x^25 + 1: feedback from state bits 35 and 24
    localparam logic [NUM_PI-1:0] LFSR_TAPS = 36'h8_0100_0000;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        COMPARE,
        DONE
    } seq_state_t;

    // The all-zero state is a lock-up state of the LFSR, so it is never loaded
    function automatic logic [NUM_PI-1:0] fix_seed(input logic [NUM_PI-1:0] seed);
        return (seed == '0) ? NUM_PI'(1) : seed;
    endfunction

endpackage

// File: rtl/c432_lfsr36.sv
// 36-bit maximal-length Fibonacci LFSR used as the pattern source of the attack drivers.
// load has priority over step; a zero seed is replaced by 1.
module c432_lfsr36
    import c432_attack_pkg::*;
#(
    parameter logic [NUM_PI-1:0] RESET_SEED = 36'h0_0000_0001
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [NUM_PI-1:0] seed,
    input  logic              step,
    output logic [NUM_PI-1:0] q
);

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= fix_seed(RESET_SEED);
        end else if (load) begin
            q <= fix_seed(seed);
        end else if (step) begin
            q <= {q[NUM_PI-2:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/c432_query_sequencer.sv
// Drives the locked c432 netlist and its oracle with LFSR patterns under a latched key,
// compares their outputs after a settle window and reports mismatch statistics.
module c432_query_sequencer
    import c432_attack_pkg::*;
#(
    parameter int                NUM_PATTERNS     = 1024,
    parameter int                SETTLE_CYCLES    = 2,
    parameter logic [NUM_PI-1:0] LFSR_SEED        = 36'h0_0000_0001,
    parameter int                STOP_ON_MISMATCH = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [NUM_KEY-1:0] key_i,
    output logic [NUM_PI-1:0]  pi_o,
    output logic [NUM_KEY-1:0] key_o,
    input  logic [NUM_PO-1:0]  locked_po_i,
    input  logic [NUM_PO-1:0]  oracle_po_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               mismatch_o,
    output logic [15:0]        mismatch_cnt_o,
    output logic [NUM_PI-1:0]  first_dip_o,
    output logic [15:0]        pat_cnt_o
);

    localparam logic [31:0] NUM_PATTERNS_U = 32'(NUM_PATTERNS);
    localparam logic [3:0]  SETTLE_LOAD    = 4'(SETTLE_CYCLES - 1);

    seq_state_t        state;
    seq_state_t        state_next;
    logic [3:0]        settle_cnt;
    logic              lfsr_load;
    logic              lfsr_step;
    logic [NUM_PI-1:0] lfsr_q;
    logic              differ;
    logic              last_pattern;

    c432_lfsr36 #(
        .RESET_SEED(LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst_n(rst_n),
        .load (lfsr_load),
        .seed (LFSR_SEED),
        .step (lfsr_step),
        .q    (lfsr_q)
    );

    assign differ       = (locked_po_i != oracle_po_i);
    assign last_pattern = ((32'(pat_cnt_o) + 32'd1) == NUM_PATTERNS_U);
    assign busy_o       = (state == APPLY) || (state == SETTLE) || (state == COMPARE);
    assign done_o       = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets its default first; a path that skips an
    // assignment would otherwise infer a latch.
    always_comb begin
        state_next = state;
        lfsr_load  = 1'b0;
        lfsr_step  = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    lfsr_load  = 1'b1;
                    state_next = (NUM_PATTERNS_U == 32'd0) ? DONE : APPLY;
                end
            end
            APPLY: begin
                lfsr_step  = 1'b1;
                state_next = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt == 4'd0) state_next = COMPARE;
            end
            COMPARE: begin
                if (last_pattern || ((STOP_ON_MISMATCH != 0) && differ)) state_next = DONE;
                else state_next = APPLY;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Result registers hold after DONE until the next accepted start clears them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt     <= '0;
            key_o          <= '0;
            pi_o           <= '0;
            mismatch_o     <= 1'b0;
            mismatch_cnt_o <= '0;
            first_dip_o    <= '0;
            pat_cnt_o      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        key_o          <= key_i;
                        mismatch_o     <= 1'b0;
                        mismatch_cnt_o <= '0;
                        first_dip_o    <= '0;
                        pat_cnt_o      <= '0;
                    end
                end
                APPLY: begin
                    pi_o       <= lfsr_q;
                    settle_cnt <= SETTLE_LOAD;
                end
                SETTLE: begin
                    if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
                end
                COMPARE: begin
                    pat_cnt_o <= pat_cnt_o + 16'd1;
                    if (differ) begin
                        if (mismatch_cnt_o != 16'hFFFF) mismatch_cnt_o <= mismatch_cnt_o + 16'd1;
                        mismatch_o <= 1'b1;
                        if (!mismatch_o) first_dip_o <= pi_o;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_c432_query_sequencer.sv
// Directed bench for c432_query_sequencer: four instances cover default runs, a single
// mismatch, stop-on-mismatch, an empty run, mid-run reset and a held start request.
module tb_c432_query_sequencer;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       start_v;
    logic [9:0]       key;
    logic [3:0][35:0] pi;
    logic [3:0][9:0]  key_q;
    logic [3:0][6:0]  locked;
    logic [3:0][6:0]  oracle;
    logic [3:0]       busy;
    logic [3:0]       done_v;
    logic [3:0]       mm;
    logic [3:0][15:0] mm_cnt;
    logic [3:0][35:0] dip;
    logic [3:0][15:0] pat;

    int checks   = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    // Netlist stand-ins: dut0 always agrees, dut1 differs only on pattern 36'h4,
    // dut2 only on pattern 36'h2, dut3 always differs.
    assign locked[0] = pi[0][6:0] ^ 7'h55;
    assign oracle[0] = pi[0][6:0] ^ 7'h55;
    assign locked[1] = (pi[1] == 36'h4) ? 7'h01 : 7'h00;
    assign oracle[1] = 7'h00;
    assign locked[2] = (pi[2] == 36'h2) ? 7'h40 : 7'h00;
    assign oracle[2] = 7'h00;
    assign locked[3] = 7'h7F;
    assign oracle[3] = 7'h00;

    c432_query_sequencer u_dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start_v[0]), .key_i(key), .pi_o(pi[0]),
        .key_o(key_q[0]), .locked_po_i(locked[0]), .oracle_po_i(oracle[0]), .busy_o(busy[0]),
        .done_o(done_v[0]), .mismatch_o(mm[0]), .mismatch_cnt_o(mm_cnt[0]),
        .first_dip_o(dip[0]), .pat_cnt_o(pat[0])
    );

    c432_query_sequencer #(
        .NUM_PATTERNS(8), .SETTLE_CYCLES(3), .LFSR_SEED(36'h0)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start_v[1]), .key_i(key), .pi_o(pi[1]),
        .key_o(key_q[1]), .locked_po_i(locked[1]), .oracle_po_i(oracle[1]), .busy_o(busy[1]),
        .done_o(done_v[1]), .mismatch_o(mm[1]), .mismatch_cnt_o(mm_cnt[1]),
        .first_dip_o(dip[1]), .pat_cnt_o(pat[1])
    );

    c432_query_sequencer #(
        .NUM_PATTERNS(8), .SETTLE_CYCLES(2), .STOP_ON_MISMATCH(1)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start_v[2]), .key_i(key), .pi_o(pi[2]),
        .key_o(key_q[2]), .locked_po_i(locked[2]), .oracle_po_i(oracle[2]), .busy_o(busy[2]),
        .done_o(done_v[2]), .mismatch_o(mm[2]), .mismatch_cnt_o(mm_cnt[2]),
        .first_dip_o(dip[2]), .pat_cnt_o(pat[2])
    );

    c432_query_sequencer #(
        .NUM_PATTERNS(0)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start_i(start_v[3]), .key_i(key), .pi_o(pi[3]),
        .key_o(key_q[3]), .locked_po_i(locked[3]), .oracle_po_i(oracle[3]), .busy_o(busy[3]),
        .done_o(done_v[3]), .mismatch_o(mm[3]), .mismatch_cnt_o(mm_cnt[3]),
        .first_dip_o(dip[3]), .pat_cnt_o(pat[3])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle start; returns sampling in cycle 1 of the run (cycle 0 = accepting edge)
    task automatic pulse_start(input int idx);
        @(negedge clk);
        start_v[idx] = 1'b1;
        @(posedge clk);
        #1;
        start_v[idx] = 1'b0;
    endtask

    // Advances from run cycle c0 until done is seen or the budget expires; returns the cycle
    task automatic wait_done(input int idx, input int c0, input int budget, output int cyc);
        cyc = c0;
        while (!done_v[idx] && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check($sformatf("done_seen_dut%0d", idx), 64'(done_v[idx]), 64'd1);
    endtask

    initial begin
        rst_n   = 1'b0;
        start_v = '0;
        key     = '0;
        tick(3);
        check("rst_pi",     64'(pi[0]),     64'd0);
        check("rst_key",    64'(key_q[0]),  64'd0);
        check("rst_busy",   64'(busy),      64'd0);
        check("rst_done",   64'(done_v),    64'd0);
        check("rst_mm",     64'(mm),        64'd0);
        check("rst_mm_cnt", 64'(mm_cnt[0]), 64'd0);
        check("rst_dip",    64'(dip[0]),    64'd0);
        check("rst_pat",    64'(pat[0]),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Default run, outputs always agree
        key = 10'h2A5;
        pulse_start(0);
        check("a_busy_c1", 64'(busy[0]), 64'd1);
        wait_done(0, 1, 5000, n);
        check("a_done_cycle", 64'(n),         64'd4097);
        check("a_pat_cnt",    64'(pat[0]),    64'd1024);
        check("a_mm_cnt",     64'(mm_cnt[0]), 64'd0);
        check("a_mm",         64'(mm[0]),     64'd0);
        check("a_dip",        64'(dip[0]),    64'd0);
        check("a_key",        64'(key_q[0]),  64'h2A5);
        check("a_busy_done",  64'(busy[0]),   64'd0);
        tick(1);
        check("a_done_pulse", 64'(done_v[0]), 64'd0);

        // Single mismatch on compare 3, settle 3, zero seed replaced by 1
        pulse_start(1);
        wait_done(1, 1, 200, n);
        check("b_done_cycle", 64'(n),         64'd41);
        check("b_mm_cnt",     64'(mm_cnt[1]), 64'd1);
        check("b_dip",        64'(dip[1]),    64'h4);
        check("b_mm",         64'(mm[1]),     64'd1);
        check("b_pat_cnt",    64'(pat[1]),    64'd8);

        // Stop on the mismatch at compare 2
        pulse_start(2);
        wait_done(2, 1, 200, n);
        check("c_done_cycle", 64'(n),         64'd9);
        check("c_pat_cnt",    64'(pat[2]),    64'd2);
        check("c_mm_cnt",     64'(mm_cnt[2]), 64'd1);
        check("c_dip",        64'(dip[2]),    64'h2);
        check("c_mm",         64'(mm[2]),     64'd1);

        // Empty run
        pulse_start(3);
        check("d_busy", 64'(busy[3]), 64'd0);
        wait_done(3, 1, 20, n);
        check("d_done_cycle", 64'(n),         64'd1);
        check("d_pat_cnt",    64'(pat[3]),    64'd0);
        check("d_mm_cnt",     64'(mm_cnt[3]), 64'd0);
        check("d_mm",         64'(mm[3]),     64'd0);
        check("d_dip",        64'(dip[3]),    64'd0);

        // Reset during the settle window of pattern 5 (cycle 18)
        key = 10'h155;
        pulse_start(0);
        tick(17);
        check("e_pi_p5",   64'(pi[0]),   64'h10);
        check("e_pat_p5",  64'(pat[0]),  64'd4);
        check("e_busy_p5", 64'(busy[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        check("e_rst_pi",   64'(pi[0]),    64'd0);
        check("e_rst_key",  64'(key_q[0]), 64'd0);
        check("e_rst_pat",  64'(pat[0]),   64'd0);
        check("e_rst_busy", 64'(busy[0]),  64'd0);
        tick(2);
        check("e_rst_done", 64'(done_v[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Held start request, key changes mid-run
        key = 10'h1C3;
        @(negedge clk);
        start_v[0] = 1'b1;
        tick(1);
        check("f_key_c1",  64'(key_q[0]), 64'h1C3);
        check("f_busy_c1", 64'(busy[0]),  64'd1);
        key = 10'h3FF;
        tick(1);
        check("f_seed_pi", 64'(pi[0]), 64'h1);
        wait_done(0, 2, 5000, n);
        check("f_done_cycle", 64'(n),         64'd4097);
        check("f_key_hold",   64'(key_q[0]),  64'h1C3);
        tick(1);
        check("f_idle_busy",  64'(busy[0]),   64'd0);
        check("f_idle_done",  64'(done_v[0]), 64'd0);
        tick(1);
        check("f_rerun_busy", 64'(busy[0]),   64'd1);
        check("f_rerun_key",  64'(key_q[0]),  64'h3FF);
        check("f_rerun_pat",  64'(pat[0]),    64'd0);
        start_v[0] = 1'b0;
        wait_done(0, 1, 5000, n);
        check("f_rerun_done", 64'(n),      64'd4097);
        check("f_rerun_cnt",  64'(pat[0]), 64'd1024);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
